// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster geometry and the per-axis phase type used by the
// VGA timing generator and its axis counters.
package vga_timing_pkg;

  localparam int POS_W = 10;

  localparam int H_ACTIVE = 640;
  localparam int H_FRONT  = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BACK   = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_ACTIVE = 480;
  localparam int V_FRONT  = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } axis_phase_e;

  // Drive level of a sync line given whether it is asserted and its polarity.
  function automatic logic sync_level(input logic asserted, input logic pol);
    if (asserted) begin
      return pol;
    end else begin
      return ~pol;
    end
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with a four-phase FSM. Next-state values are
// exported so the parent can register flags aligned with the new position.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE_LEN = 640,
  parameter int FRONT_LEN  = 16,
  parameter int SYNC_LEN   = 96,
  parameter int BACK_LEN   = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [POS_W-1:0] pos,
  output logic [POS_W-1:0] pos_next,
  output axis_phase_e      phase_next,
  output logic             wrap
);

  localparam logic [POS_W-1:0] FRONT_START = POS_W'(ACTIVE_LEN);
  localparam logic [POS_W-1:0] SYNC_START  = POS_W'(ACTIVE_LEN + FRONT_LEN);
  localparam logic [POS_W-1:0] BACK_START  = POS_W'(ACTIVE_LEN + FRONT_LEN + SYNC_LEN);
  localparam logic [POS_W-1:0] LAST_POS    = POS_W'(ACTIVE_LEN + FRONT_LEN + SYNC_LEN + BACK_LEN - 1);
  localparam logic [POS_W-1:0] POS_ZERO    = {POS_W{1'b0}};
  localparam logic [POS_W-1:0] POS_ONE     = POS_W'(1);

  axis_phase_e phase;

  // Wrap is flagged on the last position; the parent qualifies it with its enable.
  assign wrap = (pos == LAST_POS);

  // Next position and phase; phase changes on the edge the counter reaches a boundary.
  always_comb begin
    pos_next   = pos;
    phase_next = phase;
    if (en) begin
      if (wrap) begin
        pos_next = POS_ZERO;
      end else begin
        pos_next = pos + POS_ONE;
      end
      case (phase)
        ACTIVE: begin
          if (pos_next == FRONT_START) phase_next = FRONT;
          else                         phase_next = ACTIVE;
        end
        FRONT: begin
          if (pos_next == SYNC_START) phase_next = SYNC;
          else                        phase_next = FRONT;
        end
        SYNC: begin
          if (pos_next == BACK_START) phase_next = BACK;
          else                        phase_next = SYNC;
        end
        BACK: begin
          if (pos_next == POS_ZERO) phase_next = ACTIVE;
          else                      phase_next = BACK;
        end
        default: phase_next = ACTIVE;
      endcase
    end else begin
      pos_next   = pos;
      phase_next = phase;
    end
  end

  // Position and phase registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos   <= POS_ZERO;
      phase <= ACTIVE;
    end else begin
      pos   <= pos_next;
      phase <= phase_next;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: two axis counters plus a frame counter, with every
// output registered from next-state values so the whole tuple stays aligned.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter logic SYNC_POL     = 1'b1,
  parameter int   FRAME_W      = 12,
  parameter int   H_ACTIVE_LEN = H_ACTIVE,
  parameter int   H_FRONT_LEN  = H_FRONT,
  parameter int   H_SYNC_LEN   = H_SYNC,
  parameter int   H_BACK_LEN   = H_BACK,
  parameter int   V_ACTIVE_LEN = V_ACTIVE,
  parameter int   V_FRONT_LEN  = V_FRONT,
  parameter int   V_SYNC_LEN   = V_SYNC,
  parameter int   V_BACK_LEN   = V_BACK
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  output logic               hsync,
  output logic               vsync,
  output logic               display_on,
  output logic [POS_W-1:0]   hpos,
  output logic [POS_W-1:0]   vpos,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame
);

  localparam logic [POS_W-1:0]   POS_ZERO   = {POS_W{1'b0}};
  localparam logic [FRAME_W-1:0] FRAME_ZERO = {FRAME_W{1'b0}};
  localparam logic [FRAME_W-1:0] FRAME_ONE  = FRAME_W'(1);

  logic [POS_W-1:0]   h_pos_next;
  logic [POS_W-1:0]   v_pos_next;
  axis_phase_e        h_phase_next;
  axis_phase_e        v_phase_next;
  logic               h_wrap;
  logic               v_wrap;
  logic               v_en;
  logic               frame_wrap;
  logic [FRAME_W-1:0] frame_next;

  assign v_en       = ce & h_wrap;
  assign frame_wrap = v_en & v_wrap;

  vga_axis_counter #(
    .ACTIVE_LEN (H_ACTIVE_LEN),
    .FRONT_LEN  (H_FRONT_LEN),
    .SYNC_LEN   (H_SYNC_LEN),
    .BACK_LEN   (H_BACK_LEN)
  ) u_h_axis (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (ce),
    .pos        (hpos),
    .pos_next   (h_pos_next),
    .phase_next (h_phase_next),
    .wrap       (h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE_LEN (V_ACTIVE_LEN),
    .FRONT_LEN  (V_FRONT_LEN),
    .SYNC_LEN   (V_SYNC_LEN),
    .BACK_LEN   (V_BACK_LEN)
  ) u_v_axis (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (v_en),
    .pos        (vpos),
    .pos_next   (v_pos_next),
    .phase_next (v_phase_next),
    .wrap       (v_wrap)
  );

  // Frame count advances only on the combined horizontal+vertical wrap.
  always_comb begin
    frame_next = frame;
    if (frame_wrap) begin
      frame_next = frame + FRAME_ONE;
    end else begin
      frame_next = frame;
    end
  end

  // Output flags registered from next-state values of both axes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      display_on  <= 1'b1;
      line_start  <= 1'b1;
      frame_start <= 1'b1;
      frame       <= FRAME_ZERO;
    end else begin
      hsync       <= sync_level(h_phase_next == SYNC, SYNC_POL);
      vsync       <= sync_level(v_phase_next == SYNC, SYNC_POL);
      display_on  <= (h_phase_next == ACTIVE) && (v_phase_next == ACTIVE);
      line_start  <= (h_pos_next == POS_ZERO);
      frame_start <= (h_pos_next == POS_ZERO) && (v_pos_next == POS_ZERO);
      frame       <= frame_next;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size default build plus two reduced-geometry
// builds (both sync polarities, 2-bit frame counter) checked against an arithmetic raster model.
module tb_vga_timing_gen;

  localparam int SH_A = 8, SH_F = 2, SH_S = 3, SH_B = 3;
  localparam int SV_A = 6, SV_F = 2, SV_S = 2, SV_B = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic ce;

  logic       hsync_d, vsync_d, de_d, ls_d, fs_d;
  logic [9:0] hpos_d, vpos_d;
  logic [11:0] frame_d;
  logic       hsync_s, vsync_s, de_s, ls_s, fs_s;
  logic [9:0] hpos_s, vpos_s;
  logic [1:0] frame_s;
  logic       hsync_n, vsync_n, de_n, ls_n, fs_n;
  logic [9:0] hpos_n, vpos_n;
  logic [1:0] frame_n;

  int t = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_timing_gen u_dflt (
    .clk(clk), .rst_n(rst_n), .ce(ce), .hsync(hsync_d), .vsync(vsync_d),
    .display_on(de_d), .hpos(hpos_d), .vpos(vpos_d), .line_start(ls_d),
    .frame_start(fs_d), .frame(frame_d)
  );

  vga_timing_gen #(
    .SYNC_POL(1'b1), .FRAME_W(2),
    .H_ACTIVE_LEN(SH_A), .H_FRONT_LEN(SH_F), .H_SYNC_LEN(SH_S), .H_BACK_LEN(SH_B),
    .V_ACTIVE_LEN(SV_A), .V_FRONT_LEN(SV_F), .V_SYNC_LEN(SV_S), .V_BACK_LEN(SV_B)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .ce(ce), .hsync(hsync_s), .vsync(vsync_s),
    .display_on(de_s), .hpos(hpos_s), .vpos(vpos_s), .line_start(ls_s),
    .frame_start(fs_s), .frame(frame_s)
  );

  vga_timing_gen #(
    .SYNC_POL(1'b0), .FRAME_W(2),
    .H_ACTIVE_LEN(SH_A), .H_FRONT_LEN(SH_F), .H_SYNC_LEN(SH_S), .H_BACK_LEN(SH_B),
    .V_ACTIVE_LEN(SV_A), .V_FRONT_LEN(SV_F), .V_SYNC_LEN(SV_S), .V_BACK_LEN(SV_B)
  ) u_neg (
    .clk(clk), .rst_n(rst_n), .ce(ce), .hsync(hsync_n), .vsync(vsync_n),
    .display_on(de_n), .hpos(hpos_n), .vpos(vpos_n), .line_start(ls_n),
    .frame_start(fs_n), .frame(frame_n)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0d, time %0t)", name, act, exp, t, $time);
    end
  endtask

  // Expected outputs from the count of ce-qualified cycles since reset.
  task automatic check_inst(input string tag,
                            input int ha, input int hf, input int hs, input int hb,
                            input int va, input int vf, input int vs, input int vb,
                            input int fw, input bit pol,
                            input int hp, input int vp, input int fr,
                            input bit hsy, input bit vsy, input bit de, input bit ls, input bit fs);
    int ht, vt, eh, ev, ef;
    bit ehs, evs;
    ht  = ha + hf + hs + hb;
    vt  = va + vf + vs + vb;
    eh  = t % ht;
    ev  = (t / ht) % vt;
    ef  = (t / (ht * vt)) % (1 << fw);
    ehs = (eh >= ha + hf) && (eh < ha + hf + hs);
    evs = (ev >= va + vf) && (ev < va + vf + vs);
    chk({tag, ".hpos"}, hp, eh);
    chk({tag, ".vpos"}, vp, ev);
    chk({tag, ".frame"}, fr, ef);
    chk({tag, ".hsync"}, int'(hsy), int'(ehs ? pol : !pol));
    chk({tag, ".vsync"}, int'(vsy), int'(evs ? pol : !pol));
    chk({tag, ".display_on"}, int'(de), int'((eh < ha) && (ev < va)));
    chk({tag, ".line_start"}, int'(ls), int'(eh == 0));
    chk({tag, ".frame_start"}, int'(fs), int'((eh == 0) && (ev == 0)));
  endtask

  // Reference cycle count: advances on every ce-qualified edge, cleared by reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) t <= 0;
    else if (ce) t <= t + 1;
  end

  // Compare every instance against the model away from the active edge.
  always @(negedge clk) begin
    check_inst("dflt", 640, 16, 96, 48, 480, 10, 2, 33, 12, 1'b1,
               hpos_d, vpos_d, frame_d, hsync_d, vsync_d, de_d, ls_d, fs_d);
    check_inst("small", SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B, 2, 1'b1,
               hpos_s, vpos_s, frame_s, hsync_s, vsync_s, de_s, ls_s, fs_s);
    check_inst("neg", SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B, 2, 1'b0,
               hpos_n, vpos_n, frame_n, hsync_n, vsync_n, de_n, ls_n, fs_n);
  end

  initial begin
    rst_n = 1'b0;
    ce    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.hpos", hpos_d, 0);
    chk("rst.hsync", hsync_d, 0);
    chk("rst.display_on", de_d, 1);
    chk("rst.frame_start", fs_d, 1);
    chk("rst.neg_vsync", vsync_n, 1);
    rst_n = 1'b1;
    ce    = 1'b1;

    // Hand-computed horizontal landmarks of the full-size build.
    repeat (639) @(posedge clk); #1;
    chk("h639.display_on", de_d, 1);
    repeat (1) @(posedge clk); #1;
    chk("h640.hpos", hpos_d, 640);
    chk("h640.display_on", de_d, 0);
    repeat (16) @(posedge clk); #1;
    chk("h656.hpos", hpos_d, 656);
    chk("h656.hsync", hsync_d, 1);
    repeat (96) @(posedge clk); #1;
    chk("h752.hsync", hsync_d, 0);
    repeat (48) @(posedge clk); #1;
    chk("l1.hpos", hpos_d, 0);
    chk("l1.vpos", vpos_d, 1);
    chk("l1.line_start", ls_d, 1);
    chk("l1.frame_start", fs_d, 0);

    // Reduced geometry: 16x13 = 208 cycles per frame, frame wraps 3 -> 0 at t=832.
    repeat (31) @(posedge clk); #1;
    chk("s831.frame", frame_s, 3);
    chk("s831.hpos", hpos_s, 15);
    chk("s831.vpos", vpos_s, 12);
    repeat (1) @(posedge clk); #1;
    chk("s832.frame", frame_s, 0);
    chk("s832.frame_start", fs_s, 1);
    repeat (127) @(posedge clk); #1;
    chk("s959.vsync", vsync_s, 0);
    repeat (1) @(posedge clk); #1;
    chk("s960.vsync", vsync_s, 1);
    chk("s960.vpos", vpos_s, 8);
    chk("s960.neg_vsync", vsync_n, 0);
    repeat (32) @(posedge clk); #1;
    chk("s992.vsync", vsync_s, 0);
    chk("s992.neg_hsync", hsync_n, 1);

    // Alternate ce: 400 cycles yield 200 advances, t = 1192.
    @(negedge clk);
    ce = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      ce = ~ce;
    end
    chk("ce.hpos", hpos_d, 392);
    chk("ce.vpos", vpos_d, 1);
    ce = 1'b1;

    // Asynchronous reset in the middle of an hsync pulse.
    repeat (300) @(posedge clk); #1;
    chk("pre_rst.hpos", hpos_d, 692);
    chk("pre_rst.hsync", hsync_d, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.hpos", hpos_d, 0);
    chk("arst.vpos", vpos_d, 0);
    chk("arst.hsync", hsync_d, 0);
    chk("arst.display_on", de_d, 1);
    chk("arst.frame_start", fs_d, 1);
    chk("arst.neg_hsync", hsync_n, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel.hpos", hpos_d, 1);
    chk("rel.vpos", vpos_d, 0);

    repeat (1000) @(posedge clk);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Upstream timing stage for all VGA demo effects: produces the 640x480@60 Hz raster position, sync pulses, display-enable and a free-running frame counter that every effect core consumes directly. Horizontal and vertical axes are each a small four-phase counter/state machine; the vertical axis advances on horizontal wrap. All outputs are registered and mutually aligned, so a downstream effect sees a self-consistent (hpos, vpos, sync, display_on, frame) tuple on every cycle.

## Interface

Parameters:
- SYNC_POL, 1'b1, asserted level of hsync/vsync (1 = active-high, which downstream `if (vsync)` logic relies on)
- FRAME_W, 12, width of frame counter

Ports:
- clk  input  1  pixel clock (25.175 MHz nominal)
- rst_n  input  1  reset; asynchronous, active-low
- ce  input  1  clock enable; counters advance only when 1 (tie high at pixel rate)
- hsync  output  1  horizontal sync, level SYNC_POL while asserted
- vsync  output  1  vertical sync, level SYNC_POL while asserted
- display_on  output  1  1 when hpos<640 and vpos<480
- hpos  output  10  horizontal position 0..799
- vpos  output  10  vertical position 0..524
- line_start  output  1  1 while hpos==0
- frame_start  output  1  1 while hpos==0 and vpos==0
- frame  output  FRAME_W  frame count, increments on frame wrap

## Operation

- Horizontal phases (hpos): ACTIVE 0..639, FRONT 640..655, SYNC 656..751, BACK 752..799 (800 total).
- Vertical phases (vpos): ACTIVE 0..479, FRONT 480..489, SYNC 490..491, BACK 492..524 (525 total).
- Each axis: counter plus phase state; transitions ACTIVE->FRONT->SYNC->BACK->ACTIVE at the boundaries above; phase change occurs in the same cycle the counter reaches the boundary value.
- With ce=1: hpos increments each cycle; at 799 wraps to 0 and vpos increments; vpos at 524 wraps to 0 on the same horizontal wrap, and frame increments (modulo 2^FRAME_W).
- With ce=0: all outputs hold; no pulse is re-generated or lost.
- hsync asserted exactly while H phase==SYNC; vsync exactly while V phase==SYNC (full lines, independent of hpos).
- display_on = (H phase==ACTIVE) & (V phase==ACTIVE).
- Reset values: hpos=0, vpos=0, frame=0, hsync=vsync=~SYNC_POL, display_on=1, line_start=1, frame_start=1.
- Reset asserted mid-frame: all state returns to reset values immediately (async); first advance after release is to hpos=1 on the first ce=1 edge.

## Timing

- All outputs come from flops; no combinational path from ce to any output.
- Alignment: every output describes the current hpos/vpos; hsync rises in the cycle hpos becomes 656, falls when hpos becomes 752.
- vsync rises in the cycle (hpos,vpos) becomes (0,490), falls when it becomes (0,492).
- frame changes in the same cycle (hpos,vpos) becomes (0,0).
- Frame period: 420000 ce-qualified cycles; line period 800.
- Outputs derived from next-state values so phase/flags never lag the counter by one cycle.

## Structure

- Package vga_timing_pkg: H_ACTIVE/H_FRONT/H_SYNC/H_BACK/H_TOTAL, V_* equivalents, phase enum (ACTIVE, FRONT, SYNC, BACK).
- Sub-module vga_axis_counter (parameterised by the four lengths): counter, phase FSM, wrap output; instantiated once per axis, vertical instance enabled by horizontal wrap & ce.
- Top holds frame counter, sync polarity and output flags.

## Test plan

- Reset release, ce=1: after 656 cycles hsync==SYNC_POL, hpos==656; after 752 cycles hsync deasserted; display_on falls at hpos==640.
- Run one full frame: exactly 420000 cycles between frame_start pulses; frame 0->1 coincident with (0,0); vsync asserted for exactly 1600 cycles starting at (0,490).
- ce toggled 1/0 alternately: all timings double in wall cycles; outputs stable on ce=0 cycles.
- Force frame to 4095 (run 4096 frames or preset via backdoor): next wrap gives frame=0.
- Assert rst_n low at (300,200) asynchronously: outputs immediately hpos=0, vpos=0, frame=0, hsync/vsync deasserted, display_on=1.
- SYNC_POL=0 build: hsync/vsync idle high, low only in SYNC phases; other outputs identical to default.
